// File: rtl/ram_loader.sv
// ---------------------------------------------------------------------------
// ram_loader
// Sequential program loader. It takes a byte stream (valid/ready handshake)
// and writes the bytes through the RAM manual-programming port to addresses
// 0..len-1. When the load is finished it releases the RAM to run mode.
//
// Optional feature macro: RAM_LOADER_VERIFY_EN
//   defined   : after the last write every address is read back through
//               dataout_en/rd_data. The read checksum is compared with the
//               write checksum and any difference sets error.
//   undefined : there is no read-back. dataout_en and error are tied to 0,
//               and rd_data is ignored.
//
// Ports
//   clk           system clock, rising edge
//   clr_n         synchronous active-low reset (aborts any load)
//   start         begin a load (only honoured while idle)
//   len           bytes to load, 0..DEPTH, latched on start
//   byte_in       incoming program byte
//   byte_valid    byte_in is valid
//   byte_ready    loader accepts a byte this cycle
//   program_mode  RAM program_mode, high while a load is in progress
//   addr_out      RAM addr_in_manual
//   data_out      RAM data_in_manual
//   load_manual   RAM write strobe (single-cycle pulses)
//   dataout_en    RAM read-back enable (verify build only)
//   rd_data       RAM data bus for read-back
//   busy          a load is in progress
//   done          load finished; held until the next accepted start
//   error         read-back checksum mismatch; valid while done=1
// ---------------------------------------------------------------------------
module ram_loader #(
   parameter int ADDR_W = 4,
   parameter int DATA_W = 8,
   parameter int DEPTH  = 16
) (
   input  logic              clk,
   input  logic              clr_n,
   input  logic              start,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] byte_in,
   input  logic              byte_valid,
   output logic              byte_ready,
   output logic              program_mode,
   output logic [ADDR_W-1:0] addr_out,
   output logic [DATA_W-1:0] data_out,
   output logic              load_manual,
   output logic              dataout_en,
   input  logic [DATA_W-1:0] rd_data,
   output logic              busy,
   output logic              done,
   output logic              error
);

   localparam logic [2:0] ST_IDLE   = 3'd0;
   localparam logic [2:0] ST_WAIT   = 3'd1;
   localparam logic [2:0] ST_STROBE = 3'd2;
   localparam logic [2:0] ST_HOLD   = 3'd3;
   localparam logic [2:0] ST_FIN    = 3'd4;
`ifdef RAM_LOADER_VERIFY_EN
   localparam logic [2:0] ST_VADDR  = 3'd5;
   localparam logic [2:0] ST_VREAD  = 3'd6;
`endif

   localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(DEPTH);

   // Modular checksum accumulate; the carry out is discarded.
   function automatic logic [DATA_W-1:0] csum_add(input logic [DATA_W-1:0] sum,
                                                  input logic [DATA_W-1:0] val);
      return sum + val;
   endfunction

   logic [2:0]        state_r;
   logic [ADDR_W:0]   len_r;
   logic [ADDR_W:0]   count_r;
   logic [ADDR_W-1:0] addr_r;
   logic [DATA_W-1:0] data_r;
   logic [DATA_W-1:0] wsum_r;
   logic              byte_ready_r;
   logic              program_mode_r;
   logic              load_manual_r;
   logic              busy_r;
   logic              done_r;

   logic [ADDR_W:0]   len_clip_s;
   logic [ADDR_W:0]   count_inc_s;
   logic [ADDR_W-1:0] addr_inc_s;

   // An out-of-range len is clipped to DEPTH, so the address never wraps.
   assign len_clip_s  = (len > DEPTH_C) ? DEPTH_C : len;
   assign count_inc_s = count_r + (ADDR_W+1)'(1);
   assign addr_inc_s  = addr_r + ADDR_W'(1);

`ifdef RAM_LOADER_VERIFY_EN
   logic [DATA_W-1:0] rsum_r;
   logic              dataout_en_r;
   logic              error_r;
`else
   logic              unused_rd_s;
   // Without read-back, the bus and the write checksum have no consumer.
   assign unused_rd_s = ^{rd_data, wsum_r};
`endif

   // Loader FSM. All outputs are registered and updated on the edge that
   // enters the state they belong to.
   always_ff @(posedge clk) begin
      if (!clr_n) begin
         state_r        <= ST_IDLE;
         len_r          <= '0;
         count_r        <= '0;
         addr_r         <= '0;
         data_r         <= '0;
         wsum_r         <= '0;
         byte_ready_r   <= 1'b0;
         program_mode_r <= 1'b0;
         load_manual_r  <= 1'b0;
         busy_r         <= 1'b0;
         done_r         <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
         rsum_r         <= '0;
         dataout_en_r   <= 1'b0;
         error_r        <= 1'b0;
`endif
      end else begin
         // Strobes default low, so each one lasts exactly one cycle.
         load_manual_r <= 1'b0;
         byte_ready_r  <= 1'b0;
`ifdef RAM_LOADER_VERIFY_EN
         dataout_en_r  <= 1'b0;
`endif
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  len_r   <= len_clip_s;
                  count_r <= '0;
                  addr_r  <= '0;
                  wsum_r  <= '0;
`ifdef RAM_LOADER_VERIFY_EN
                  error_r <= 1'b0;
`endif
                  if (len_clip_s == '0) begin
                     // An empty load completes at once.
                     state_r        <= ST_FIN;
                     busy_r         <= 1'b0;
                     program_mode_r <= 1'b0;
                     done_r         <= 1'b1;
                  end else begin
                     state_r        <= ST_WAIT;
                     busy_r         <= 1'b1;
                     program_mode_r <= 1'b1;
                     done_r         <= 1'b0;
                     byte_ready_r   <= 1'b1;
                  end
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_WAIT: begin
               if (byte_valid && byte_ready_r) begin
                  data_r        <= byte_in;
                  wsum_r        <= csum_add(wsum_r, byte_in);
                  load_manual_r <= 1'b1;
                  state_r       <= ST_STROBE;
               end else begin
                  byte_ready_r  <= 1'b1;
                  state_r       <= ST_WAIT;
               end
            end
            ST_STROBE: begin
               state_r <= ST_HOLD;
            end
            ST_HOLD: begin
               count_r <= count_inc_s;
               if (count_inc_s == len_r) begin
`ifdef RAM_LOADER_VERIFY_EN
                  // Restart the counters for the read-back pass.
                  state_r <= ST_VADDR;
                  addr_r  <= '0;
                  count_r <= '0;
                  rsum_r  <= '0;
`else
                  // Keep addr_out on the last written address.
                  state_r        <= ST_FIN;
                  busy_r         <= 1'b0;
                  program_mode_r <= 1'b0;
                  done_r         <= 1'b1;
`endif
               end else begin
                  addr_r       <= addr_inc_s;
                  byte_ready_r <= 1'b1;
                  state_r      <= ST_WAIT;
               end
            end
`ifdef RAM_LOADER_VERIFY_EN
            ST_VADDR: begin
               dataout_en_r <= 1'b1;
               state_r      <= ST_VREAD;
            end
            ST_VREAD: begin
               rsum_r  <= csum_add(rsum_r, rd_data);
               count_r <= count_inc_s;
               if (count_inc_s == len_r) begin
                  // The final byte is folded in here so that no extra cycle is needed.
                  error_r        <= (csum_add(rsum_r, rd_data) != wsum_r);
                  state_r        <= ST_FIN;
                  busy_r         <= 1'b0;
                  program_mode_r <= 1'b0;
                  done_r         <= 1'b1;
               end else begin
                  addr_r  <= addr_inc_s;
                  state_r <= ST_VADDR;
               end
            end
`endif
            ST_FIN: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r        <= ST_IDLE;
               busy_r         <= 1'b0;
               program_mode_r <= 1'b0;
            end
         endcase
      end
   end

   assign byte_ready   = byte_ready_r;
   assign program_mode = program_mode_r;
   assign addr_out     = addr_r;
   assign data_out     = data_r;
   assign load_manual  = load_manual_r;
   assign busy         = busy_r;
   assign done         = done_r;
`ifdef RAM_LOADER_VERIFY_EN
   assign dataout_en   = dataout_en_r;
   assign error        = error_r;
`else
   assign dataout_en   = 1'b0;
   assign error        = 1'b0;
`endif

endmodule

// File: tb/tb_ram_loader.sv
// Testbench for ram_loader: a scoreboard paired with a RAM model, driven by
// randomised byte streams.
module tb_ram_loader;

`ifdef RAM_LOADER_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   typedef struct {
      int addr;
      int data;
   } wr_t;

   logic       clk = 1'b0;
   logic       clr_n = 1'b0;
   logic       start = 1'b0;
   logic [4:0] len = 5'd0;
   logic [7:0] byte_in = 8'd0;
   logic       byte_valid = 1'b0;
   logic       byte_ready, program_mode, load_manual, dataout_en, busy, done, error;
   logic [3:0] addr_out;
   logic [7:0] data_out;
   logic [7:0] rd_data;

   logic [7:0] mem [16];
   logic [7:0] bytes [16];
   logic       mem_clr = 1'b0;
   logic       corrupt = 1'b0;

   wr_t exp_q[$];
   int  n_vec = 0;
   int  n_err = 0;
   int  n_wr = 0;
   int  cyc = 0;
   bit  prev_lm = 1'b0;
   bit  prev_clr = 1'b0;
   int  lm_addr = 0;
   int  lm_data = 0;

   ram_loader #(.ADDR_W(4), .DATA_W(8), .DEPTH(16)) dut (
      .clk(clk), .clr_n(clr_n), .start(start), .len(len),
      .byte_in(byte_in), .byte_valid(byte_valid), .byte_ready(byte_ready),
      .program_mode(program_mode), .addr_out(addr_out), .data_out(data_out),
      .load_manual(load_manual), .dataout_en(dataout_en), .rd_data(rd_data),
      .busy(busy), .done(done), .error(error)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // RAM model: write on load_manual and read combinationally on dataout_en.
   // The corrupt hook makes address 1 read back as 0x07.
   always @(posedge clk) begin
      if (mem_clr) begin
         for (int i = 0; i < 16; i++) mem[i] <= 8'hEE;
      end else if (load_manual) begin
         mem[addr_out] <= data_out;
      end
   end
   assign rd_data = !dataout_en ? 8'h00 :
                    (corrupt && addr_out == 4'd1) ? 8'h07 : mem[addr_out];

   task automatic chk(input string nm, input int act, input int exp);
      n_vec++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Monitor: pop the scoreboard on each write strobe. Strobes must not be
   // back-to-back, and addr/data must stay stable in the cycle after a strobe.
   always @(negedge clk) begin
      wr_t e;
      if (clr_n && prev_clr && prev_lm) begin
         chk("addr_stable_after_strobe", int'(addr_out), lm_addr);
         chk("data_stable_after_strobe", int'(data_out), lm_data);
      end
      if (load_manual) begin
         chk("strobe_gap", int'(prev_lm), 0);
         n_wr++;
         if (exp_q.size() == 0) begin
            chk("unexpected_write", 1, 0);
         end else begin
            e = exp_q.pop_front();
            chk("write_addr", int'(addr_out), e.addr);
            chk("write_data", int'(data_out), e.data);
         end
      end
      prev_lm  = load_manual;
      prev_clr = clr_n;
      lm_addr  = int'(addr_out);
      lm_data  = int'(data_out);
   end

   task automatic chk_all_zero(input string tag);
      chk({tag, "_byte_ready"}, int'(byte_ready), 0);
      chk({tag, "_program_mode"}, int'(program_mode), 0);
      chk({tag, "_addr_out"}, int'(addr_out), 0);
      chk({tag, "_data_out"}, int'(data_out), 0);
      chk({tag, "_load_manual"}, int'(load_manual), 0);
      chk({tag, "_dataout_en"}, int'(dataout_en), 0);
      chk({tag, "_busy"}, int'(busy), 0);
      chk({tag, "_done"}, int'(done), 0);
      chk({tag, "_error"}, int'(error), 0);
   endtask

   // Offer bytes[0..n-1] to the loader, with optional random valid gaps.
   // If poke >= 0, a start with len=9 is also pulsed while byte index poke
   // is on offer.
   task automatic feed(input int n, input bit gaps, input int poke);
      int  i = 0;
      int  guard = 0;
      bit  acc;
      bit  poked = 1'b0;
      while (i < n && guard < 2000) begin
         guard++;
         if (gaps && $urandom_range(0, 2) == 0) begin
            byte_valid = 1'b0;
            byte_in    = 8'($urandom);
         end else begin
            byte_valid = 1'b1;
            byte_in    = bytes[i];
         end
         if (i == poke && !poked) begin
            start = 1'b1;
            len   = 5'd9;
            poked = 1'b1;
         end
         @(negedge clk);
         acc = byte_valid && byte_ready;
         @(posedge clk);
         #1;
         start = 1'b0;
         if (acc) i++;
      end
      byte_valid = 1'b0;
      if (guard >= 2000) chk("feed_timeout", 0, 1);
   endtask

   // One complete load, checked against the rules: byte k goes to address k.
   // Done arrives 3*n edges after start (5*n with read-back), and the error
   // flag reflects whether read-back was corrupted.
   task automatic run_load(input int n, input bit gaps, input int poke, input int exp_err);
      int  t0;
      int  lat;
      int  wr0;
      bit  got = 1'b0;
      mem_clr = 1'b1;
      @(posedge clk);
      #1;
      mem_clr = 1'b0;
      for (int i = 0; i < n; i++) exp_q.push_back('{addr: i, data: int'(bytes[i])});
      wr0   = n_wr;
      len   = 5'(n);
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      t0    = cyc;
      if (n > 0) feed(n, gaps, poke);
      for (int k = 0; k < 400 && !got; k++) begin
         @(negedge clk);
         if (done) got = 1'b1;
      end
      lat = cyc - t0;
      chk("done_seen", int'(got), 1);
      if (!gaps) chk("done_latency", lat, VERIFY ? 5 * n : 3 * n);
      chk("fin_busy", int'(busy), 0);
      chk("fin_program_mode", int'(program_mode), 0);
      chk("fin_error", int'(error), exp_err);
      chk("write_count", n_wr - wr0, n);
      chk("queue_drained", exp_q.size(), 0);
      for (int i = 0; i < n; i++) chk("ram_content", int'(mem[i]), int'(bytes[i]));
      if (n > 0) begin
         chk("final_addr_out", int'(addr_out), n - 1);
         chk("final_data_out", int'(data_out), int'(bytes[n - 1]));
      end
      repeat (3) @(negedge clk);
      chk("done_held", int'(done), 1);
      chk("idle_busy", int'(busy), 0);
      exp_q.delete();
   endtask

   initial begin
      // Reset state.
      clr_n = 1'b0;
      @(posedge clk);
      @(negedge clk);
      chk_all_zero("reset");
      @(posedge clk);
      #1;
      clr_n = 1'b1;

      // Reset mid-load: len=16, 5 bytes written, then a 1-cycle clr_n.
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      for (int i = 0; i < 16; i++) exp_q.push_back('{addr: i, data: int'(bytes[i])});
      len   = 5'd16;
      start = 1'b1;
      @(posedge clk);
      #1;
      start = 1'b0;
      feed(5, 1'b0, -1);
      clr_n = 1'b0;
      @(posedge clk);
      #1;
      clr_n = 1'b1;
      exp_q.delete();
      @(negedge clk);
      chk_all_zero("abort");

      // Basic load with byte_valid held high.
      bytes[0] = 8'h1A;
      bytes[1] = 8'h2B;
      bytes[2] = 8'h3C;
      run_load(3, 1'b0, -1, 0);

      // Full depth with source stalls.
      for (int i = 0; i < 16; i++) bytes[i] = 8'(8'hF0 + i);
      run_load(16, 1'b1, -1, 0);

      // Empty load.
      run_load(0, 1'b0, -1, 0);

      // A second start during a len=4 load must be ignored.
      for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
      run_load(4, 1'b0, 2, 0);

      // Randomised loads.
      for (int r = 0; r < 5; r++) begin
         for (int i = 0; i < 16; i++) bytes[i] = 8'($urandom);
         run_load($urandom_range(1, 16), r[0], -1, 0);
      end

      // Read-back: a clean RAM, then a corrupted mem[1] (only the verify
      // build can flag it).
      bytes[0] = 8'h01;
      bytes[1] = 8'h02;
      bytes[2] = 8'h03;
      run_load(3, 1'b0, -1, 0);
      corrupt = 1'b1;
      run_load(3, 1'b0, -1, VERIFY ? 1 : 0);
      chk("corrupt_done", int'(done), 1);
      corrupt = 1'b0;

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
